// File: rtl/cpu_defs_pkg.sv
// Shared fetch-path definitions: widths, reset PC, fetch FSM states, queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h1c00_0000;

    // Bubble instruction injected by decode (andi r0, r0, 0).
    localparam logic [INST_W-1:0] NOP_INST = 32'h0340_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Circular FIFO of fetched {pc, inst} entries feeding decode.
// Latency: a push is visible at the head one cycle later (registered storage).
// Backpressure: caller reserves space before pushing; clear wins over push/pop.
// Ports: push/push_dat write, pop advances head, clear empties, head_dat/count/empty status.
module fetch_queue
    import cpu_defs::*;
#(
    parameter int QDEPTH = 4,
    localparam int PW    = $clog2(QDEPTH),
    localparam int CW    = PW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_dat,
    input  logic               pop,
    input  logic               clear,
    output fetch_entry_t       head_dat,
    output logic [CW-1:0]      count,
    output logic               empty
);

    fetch_entry_t  mem_q [QDEPTH];
    fetch_entry_t  mem_d [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        full     = (count_q == CW'(QDEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        head_dat = mem_q[head_q];
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = push_dat;
                tail_d        = tail_q + 1'b1;
            end
            if (pop_ok) begin
                head_d = head_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // Storage is zeroed so an empty head never reads as X.
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues one Icache read at a time, queues {pc, inst} to decode.
// Latency: Icache response reaches id_* one cycle after ic_rready; empty-queue fetch = Icache latency + 1.
// Backpressure: a queue slot is reserved at issue, so issue stalls while count + outstanding == QDEPTH.
// Ports: clk/rst; redirect_valid/redirect_pc/uncache_in control; ic_* Icache request/response; id_* decode handshake.
module ifetch_unit
    import cpu_defs::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              uncache_in,
    output logic              ic_rvalid,
    output logic [ADDR_W-1:0] ic_raddr,
    output logic              ic_flush,
    output logic              ic_uncache,
    input  logic              ic_rready,
    input  logic [INST_W-1:0] ic_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              uncache_q, uncache_d;

    fetch_entry_t      q_head;
    fetch_entry_t      q_push_dat;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;

    logic              outstanding;
    logic [CW:0]       used;
    logic              space_ok;
    logic              issue;

    always_comb begin
        outstanding = (state_q != ST_IDLE);
        used        = {1'b0, q_count} + {{CW{1'b0}}, outstanding};
        space_ok    = (used < (CW+1)'(QDEPTH));
        // A redirect cycle never issues: the PC being replaced is already stale.
        issue       = !rst && !redirect_valid && (state_q == ST_IDLE) && space_ok;

        ic_rvalid   = !rst && (issue || state_q != ST_IDLE);
        ic_raddr    = rst ? RESET_PC : ((state_q == ST_IDLE) ? pc_q : req_addr_q);
        ic_uncache  = ic_rvalid && (issue ? uncache_in : uncache_q);
        ic_flush    = !rst && redirect_valid;

        id_valid    = !rst && !q_empty;
        id_pc       = rst ? '0 : q_head.pc;
        id_inst     = rst ? '0 : q_head.inst;
        q_pop       = id_valid && id_ready;

        q_push_dat.pc   = req_addr_q;
        q_push_dat.inst = ic_rdata;

        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        uncache_d  = uncache_q;
        q_push     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d    = ST_REQ;
                    req_addr_d = pc_q;
                    uncache_d  = uncache_in;
                end
            end
            ST_REQ: begin
                if (ic_rready) begin
                    q_push  = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    // Back-to-back issue happens from IDLE if space remains.
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // pc_q already holds the newest redirect target.
                if (ic_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d   = align_pc(redirect_pc);
            q_push = 1'b0;
            if (state_q == ST_REQ && !ic_rready) begin
                state_d = ST_DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            uncache_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            uncache_q  <= uncache_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .clear    (redirect_valid),
        .head_dat (q_head),
        .count    (q_count),
        .empty    (q_empty)
    );

endmodule
